// File: rtl/axis_frame_gen_chk.sv
// AXI-Stream frame generator and loopback checker: sends N incrementing beats from a
// seed, checks the returning stream, and reports errors, timeout and pass/fail per test.
//
// generator  | meaning
// G_IDLE     | no test running
// G_SEND     | issuing beats S+0 .. S+N-1
// G_FIN      | all beats sent (or timeout), waiting for checker
//
// checker    | meaning
// C_IDLE     | no test running
// C_RECV     | comparing received beats against S+k
// C_DRAIN    | N beats seen without tlast, discarding until tlast
// C_FIN      | frame closed (tlast, early tlast or timeout), waiting for generator
module axis_frame_gen_chk #(
   parameter int DataWidth     = 64,
   parameter int UserWidth     = 1,
   parameter int CntWidth      = 16,
   parameter int TimeoutCycles = 1024
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [CntWidth-1:0]  num_beats_i,
   input  logic [DataWidth-1:0] seed_i,
   output logic [DataWidth-1:0] tx_tdata_o,
   output logic                 tx_tvalid_o,
   input  logic                 tx_tready_i,
   output logic                 tx_tlast_o,
   output logic [UserWidth-1:0] tx_tuser_o,
   input  logic [DataWidth-1:0] rx_tdata_i,
   input  logic                 rx_tvalid_i,
   output logic                 rx_tready_o,
   input  logic                 rx_tlast_i,
   input  logic [UserWidth-1:0] rx_tuser_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 pass_o,
   output logic                 timeout_o,
   output logic [CntWidth-1:0]  err_cnt_o,
   output logic [CntWidth-1:0]  frames_o
);

   localparam int ToWidth = $clog2(TimeoutCycles + 1);

   typedef enum logic [1:0] {G_IDLE, G_SEND, G_FIN} gen_state_t;
   typedef enum logic [1:0] {C_IDLE, C_RECV, C_DRAIN, C_FIN} chk_state_t;

   gen_state_t gen_q, gen_d;
   chk_state_t chk_q, chk_d;

   logic [CntWidth-1:0]  n_q, tx_k_q, rx_k_q, err_q, err_d, frames_q;
   logic [DataWidth-1:0] s_q;
   logic [ToWidth-1:0]   to_q;
   logic                 pass_q, timeout_q, done_q;
   logic                 accept, tx_hs, rx_hs, tx_last, rx_last_k, to_fire, finish;
   logic [1:0]           err_inc;
   logic [CntWidth:0]    err_sum;

   assign busy_o      = (gen_q != G_IDLE) || (chk_q != C_IDLE);
   assign accept      = start_i && !busy_o;
   assign tx_tvalid_o = (gen_q == G_SEND);
   assign tx_last     = (tx_k_q == n_q - CntWidth'(1));
   assign tx_tlast_o  = tx_tvalid_o && tx_last;
   assign tx_tdata_o  = tx_tvalid_o ? (s_q + DataWidth'(tx_k_q)) : '0;
   assign tx_tuser_o  = '0;
   assign tx_hs       = tx_tvalid_o && tx_tready_i;
   assign rx_tready_o = (chk_q == C_RECV) || (chk_q == C_DRAIN);
   assign rx_hs       = rx_tready_o && rx_tvalid_i;
   assign rx_last_k   = (rx_k_q == n_q - CntWidth'(1));
   // to_q counts down idle receive cycles; zero on an idle cycle is the last allowed one
   assign to_fire     = rx_tready_o && !rx_hs && (to_q == '0);
   assign finish      = (gen_q == G_FIN) && (chk_q == C_FIN);

   assign done_o    = done_q;
   assign pass_o    = pass_q;
   assign timeout_o = timeout_q;
   assign err_cnt_o = err_q;
   assign frames_o  = frames_q;

   always_comb begin
      err_inc = '0;
      if (chk_q == C_RECV && rx_hs) begin
         // tlast mismatch covers both early tlast and missing tlast on beat N-1
         err_inc = 2'(rx_tdata_i != (s_q + DataWidth'(rx_k_q)))
                 + 2'(rx_tuser_i != '0)
                 + 2'(rx_tlast_i != rx_last_k);
      end
      if (to_fire) err_inc = 2'd1;
      err_sum = {1'b0, err_q} + (CntWidth + 1)'(err_inc);
      err_d   = err_sum[CntWidth] ? '1 : err_sum[CntWidth-1:0];
   end

   always_comb begin
      gen_d = gen_q;
      case (gen_q)
         G_IDLE:  if (accept) gen_d = G_SEND;
         G_SEND:  if (tx_hs && tx_last) gen_d = G_FIN;
         G_FIN:   if (finish) gen_d = G_IDLE;
         default: gen_d = G_IDLE;
      endcase
      if (to_fire) gen_d = G_FIN;
   end

   always_comb begin
      chk_d = chk_q;
      case (chk_q)
         C_IDLE:  if (accept) chk_d = C_RECV;
         C_RECV:  if (rx_hs && (rx_tlast_i || rx_last_k)) chk_d = rx_tlast_i ? C_FIN : C_DRAIN;
         C_DRAIN: if (rx_hs && rx_tlast_i) chk_d = C_FIN;
         C_FIN:   if (finish) chk_d = C_IDLE;
         default: chk_d = C_IDLE;
      endcase
      if (to_fire) chk_d = C_FIN;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         gen_q     <= G_IDLE;
         chk_q     <= C_IDLE;
         n_q       <= '0;
         s_q       <= '0;
         tx_k_q    <= '0;
         rx_k_q    <= '0;
         err_q     <= '0;
         frames_q  <= '0;
         to_q      <= '0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         gen_q  <= gen_d;
         chk_q  <= chk_d;
         done_q <= finish;
         if (accept) begin
            n_q       <= (num_beats_i == '0) ? CntWidth'(1) : num_beats_i;
            s_q       <= seed_i;
            tx_k_q    <= '0;
            rx_k_q    <= '0;
            err_q     <= '0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            to_q      <= ToWidth'(TimeoutCycles - 1);
         end else begin
            if (tx_hs) tx_k_q <= tx_k_q + CntWidth'(1);
            if (rx_hs) rx_k_q <= rx_k_q + CntWidth'(1);
            err_q <= err_d;
            if (rx_hs) to_q <= ToWidth'(TimeoutCycles - 1);
            else if (rx_tready_o && to_q != '0) to_q <= to_q - ToWidth'(1);
            if (to_fire) timeout_q <= 1'b1;
            if (finish) begin
               pass_q   <= (err_q == '0) && !timeout_q;
               frames_q <= frames_q + CntWidth'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_axis_frame_gen_chk.sv
// Directed bench for axis_frame_gen_chk: loopback, stalls, corrupted beat, early tlast,
// receive timeout, ignored start while busy and mid-test reset.
module tb_axis_frame_gen_chk;
   localparam int DW = 64;
   localparam int UW = 1;
   localparam int CW = 16;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst, start;
   logic [CW-1:0] num_beats;
   logic [DW-1:0] seed;
   logic [DW-1:0] tx_tdata, rx_tdata;
   logic          tx_tvalid, tx_tready, tx_tlast, rx_tvalid, rx_tready, rx_tlast;
   logic [UW-1:0] tx_tuser, rx_tuser;
   logic          busy, done, pass, timeout;
   logic [CW-1:0] err_cnt, frames;

   logic          loop, rdy_en, tx_ready_drv, rx_valid_drv, rx_last_drv;
   logic [DW-1:0] rx_data_drv;
   logic [UW-1:0] rx_user_drv;
   int            flip_beat, tx_cnt;
   int            total = 0, bad = 0;

   always #5 clk = ~clk;

   assign tx_tready = loop ? (rx_tready && rdy_en) : tx_ready_drv;
   assign rx_tvalid = loop ? (tx_tvalid && rdy_en) : rx_valid_drv;
   assign rx_tdata  = loop ? (tx_tdata ^ ((tx_cnt == flip_beat) ? 64'd1 : 64'd0)) : rx_data_drv;
   assign rx_tlast  = loop ? tx_tlast : rx_last_drv;
   assign rx_tuser  = loop ? tx_tuser : rx_user_drv;

   always @(posedge clk) begin
      if (start && !busy) tx_cnt <= 0;
      else if (tx_tvalid && tx_tready) tx_cnt <= tx_cnt + 1;
   end

   axis_frame_gen_chk #(.DataWidth(DW), .UserWidth(UW), .CntWidth(CW), .TimeoutCycles(TO)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .num_beats_i(num_beats), .seed_i(seed),
      .tx_tdata_o(tx_tdata), .tx_tvalid_o(tx_tvalid), .tx_tready_i(tx_tready),
      .tx_tlast_o(tx_tlast), .tx_tuser_o(tx_tuser),
      .rx_tdata_i(rx_tdata), .rx_tvalid_i(rx_tvalid), .rx_tready_o(rx_tready),
      .rx_tlast_i(rx_tlast), .rx_tuser_i(rx_tuser),
      .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(timeout),
      .err_cnt_o(err_cnt), .frames_o(frames)
   );

   // Leaves the bench at the negedge of the first SEND cycle.
   task automatic pulse_start(input logic [CW-1:0] n, input logic [DW-1:0] s);
      @(negedge clk);
      start = 1'b1; num_beats = n; seed = s;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_results(input string name, input logic exp_pass, input logic exp_to,
                                input logic [CW-1:0] exp_err, input logic [CW-1:0] exp_frames);
      total++;
      if (pass !== exp_pass || timeout !== exp_to || err_cnt !== exp_err || frames !== exp_frames
          || busy !== 1'b0) begin
         bad++;
         $display("FAIL %s results: pass=%b to=%b err=%0d frames=%0d busy=%b, want %b %b %0d %0d 0",
                  name, pass, timeout, err_cnt, frames, busy, exp_pass, exp_to, exp_err, exp_frames);
      end
   endtask

   task automatic test_reset;
      total++;
      if ({busy, done, pass, timeout, tx_tvalid, tx_tlast, rx_tready} !== 7'b0) begin
         bad++;
         $display("FAIL reset_flags: got %b want 0000000",
                  {busy, done, pass, timeout, tx_tvalid, tx_tlast, rx_tready});
      end
      total++;
      if (err_cnt !== '0 || frames !== '0 || tx_tdata !== '0) begin
         bad++;
         $display("FAIL reset_counts: err=%0d frames=%0d tdata=%h want 0", err_cnt, frames, tx_tdata);
      end
   endtask

   task automatic test_loopback;
      logic [DW-1:0] s;
      int k, first, last, dones;
      s = 64'h1032207098001032;
      loop = 1'b1; rdy_en = 1'b1; flip_beat = -1;
      k = 0; first = -1; last = -1; dones = 0;
      pulse_start(16'd8, s);
      for (int c = 0; c < 20; c++) begin
         if (tx_tvalid && tx_tready) begin
            total++;
            if (tx_tdata !== s + 64'(k) || tx_tlast !== (k == 7)) begin
               bad++;
               $display("FAIL loop_beat%0d: data=%h last=%b want %h %b", k, tx_tdata, tx_tlast,
                        s + 64'(k), (k == 7));
            end
            if (first < 0) first = c;
            last = c;
            k++;
         end
         if (done) dones++;
         @(negedge clk);
      end
      total++;
      if (k != 8 || first != 0 || last != 7) begin
         bad++;
         $display("FAIL loop_timing: beats=%0d first=%0d last=%0d want 8 0 7", k, first, last);
      end
      total++;
      if (dones != 1) begin
         bad++;
         $display("FAIL loop_done: pulses=%0d want 1", dones);
      end
      check_results("loopback", 1'b1, 1'b0, 16'd0, 16'd1);
   endtask

   task automatic test_stall;
      logic [DW-1:0] s, prev;
      logic prev_stall;
      int k, dones;
      s = 64'hFFFF_FFFF_FFFF_FFFE;
      loop = 1'b1; flip_beat = -1; k = 0; dones = 0; prev_stall = 1'b0; prev = '0;
      pulse_start(16'd4, s);
      for (int c = 0; c < 60; c++) begin
         rdy_en = (c == 0 || c == 2) ? 1'b0 : 1'(($urandom_range(0, 3) != 0));
         #1;
         if (prev_stall) begin
            total++;
            if (tx_tvalid !== 1'b1 || tx_tdata !== prev) begin
               bad++;
               $display("FAIL stall_hold c%0d: valid=%b data=%h want 1 %h", c, tx_tvalid, tx_tdata, prev);
            end
         end
         if (tx_tvalid && tx_tready) begin
            total++;
            if (tx_tdata !== s + 64'(k)) begin
               bad++;
               $display("FAIL stall_beat%0d: data=%h want %h", k, tx_tdata, s + 64'(k));
            end
            k++;
         end
         prev_stall = tx_tvalid && !tx_tready;
         prev = tx_tdata;
         if (done) dones++;
         @(negedge clk);
      end
      rdy_en = 1'b1;
      total++;
      if (k != 4 || dones != 1) begin
         bad++;
         $display("FAIL stall_count: beats=%0d dones=%0d want 4 1", k, dones);
      end
      check_results("stall", 1'b1, 1'b0, 16'd0, 16'd2);
   endtask

   task automatic test_flip;
      int dones;
      loop = 1'b1; rdy_en = 1'b1; flip_beat = 2; dones = 0;
      pulse_start(16'd8, 64'h0123_4567_89AB_CDEF);
      for (int c = 0; c < 20; c++) begin
         if (done) dones++;
         @(negedge clk);
      end
      flip_beat = -1;
      total++;
      if (dones != 1) begin
         bad++;
         $display("FAIL flip_done: pulses=%0d want 1", dones);
      end
      check_results("flip", 1'b0, 1'b0, 16'd1, 16'd3);
   endtask

   task automatic test_one_beat;
      int beats;
      loop = 1'b1; rdy_en = 1'b1; flip_beat = -1; beats = 0;
      pulse_start(16'd0, 64'hA5);
      for (int c = 0; c < 10; c++) begin
         if (tx_tvalid && tx_tready) begin
            beats++;
            total++;
            if (tx_tlast !== 1'b1 || tx_tdata !== 64'hA5) begin
               bad++;
               $display("FAIL one_beat: last=%b data=%h want 1 a5", tx_tlast, tx_tdata);
            end
         end
         @(negedge clk);
      end
      total++;
      if (beats != 1) begin
         bad++;
         $display("FAIL one_beat_count: beats=%0d want 1", beats);
      end
      check_results("one_beat", 1'b1, 1'b0, 16'd0, 16'd4);
   endtask

   task automatic test_early_last;
      logic [DW-1:0] s;
      int done_cyc;
      s = 64'h1000;
      loop = 1'b0; tx_ready_drv = 1'b1; rx_valid_drv = 1'b0; done_cyc = -1;
      pulse_start(16'd8, s);
      for (int k = 0; k < 3; k++) begin
         rx_valid_drv = 1'b1; rx_data_drv = s + 64'(k); rx_last_drv = (k == 2); rx_user_drv = '0;
         @(negedge clk);
      end
      rx_valid_drv = 1'b0; rx_last_drv = 1'b0;
      total++;
      if (rx_tready !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL early_chk_fin: rready=%b busy=%b want 0 1", rx_tready, busy);
      end
      // generator beats in cycles 0..7, both FIN in cycle 8, done in cycle 9
      for (int c = 3; c < 30; c++) begin
         if (done && done_cyc < 0) done_cyc = c;
         @(negedge clk);
      end
      total++;
      if (done_cyc != 9) begin
         bad++;
         $display("FAIL early_done_cycle: got %0d want 9", done_cyc);
      end
      check_results("early_last", 1'b0, 1'b0, 16'd1, 16'd5);
   endtask

   task automatic test_timeout;
      logic [DW-1:0] s;
      int done_cyc, to_cyc;
      s = 64'h2000;
      loop = 1'b0; tx_ready_drv = 1'b1; rx_valid_drv = 1'b0; done_cyc = -1; to_cyc = -1;
      pulse_start(16'd8, s);
      for (int k = 0; k < 3; k++) begin
         rx_valid_drv = 1'b1; rx_data_drv = s + 64'(k); rx_last_drv = 1'b0; rx_user_drv = '0;
         @(negedge clk);
      end
      rx_valid_drv = 1'b0;
      // last handshake in cycle 2; idle cycles 3..18 -> timeout visible in 19, done in 20
      for (int c = 3; c < 40; c++) begin
         if (timeout && to_cyc < 0) to_cyc = c;
         if (done && done_cyc < 0) done_cyc = c;
         @(negedge clk);
      end
      total++;
      if (to_cyc != 19 || done_cyc != 20) begin
         bad++;
         $display("FAIL timeout_cycles: timeout at %0d done at %0d want 19 20", to_cyc, done_cyc);
      end
      check_results("timeout", 1'b0, 1'b1, 16'd1, 16'd6);
   endtask

   task automatic test_busy_reset;
      int dones;
      loop = 1'b1; rdy_en = 1'b0; flip_beat = -1; dones = 0;
      pulse_start(16'd8, 64'h3000);
      @(negedge clk);
      pulse_start(16'd2, 64'h9999);
      total++;
      if (busy !== 1'b1 || tx_tvalid !== 1'b1 || tx_tdata !== 64'h3000 || err_cnt !== '0) begin
         bad++;
         $display("FAIL busy_ignore: busy=%b valid=%b data=%h err=%0d want 1 1 3000 0",
                  busy, tx_tvalid, tx_tdata, err_cnt);
      end
      rdy_en = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({busy, done, pass, timeout, tx_tvalid, rx_tready} !== 6'b0 || err_cnt !== '0
          || frames !== '0 || tx_tdata !== '0) begin
         bad++;
         $display("FAIL midtest_reset: flags=%b err=%0d frames=%0d data=%h want 0",
                  {busy, done, pass, timeout, tx_tvalid, rx_tready}, err_cnt, frames, tx_tdata);
      end
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (done) dones++;
         @(negedge clk);
      end
      total++;
      if (dones != 0 || frames !== '0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL after_reset: dones=%0d frames=%0d busy=%b want 0 0 0", dones, frames, busy);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; num_beats = '0; seed = '0;
      loop = 1'b0; rdy_en = 1'b1; flip_beat = -1;
      tx_ready_drv = 1'b0; rx_valid_drv = 1'b0; rx_last_drv = 1'b0;
      rx_data_drv = '0; rx_user_drv = '0;
      repeat (3) @(negedge clk);
      test_reset;
      rst = 1'b0;
      test_loopback;
      test_stall;
      test_flip;
      test_one_beat;
      test_early_last;
      test_timeout;
      test_busy_reset;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
